// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronises and debounces switch/key lines, latches
// press events as sticky flags and returns them on CPU loads inside its window.
module mmio_input_port #(
   parameter int          N_IN       = 8,
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          TICK_DIV   = 1000,
   parameter int          STABLE_CNT = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [N_IN-1:0] sw_in,
   input  logic [15:0]     addr,
   input  logic            rd_en,
   output logic [15:0]     rd_data,
   output logic            hit,
   output logic            irq_pending
);

   localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [15:0] ADDR_STATE = BASE_ADDR;
   localparam logic [15:0] ADDR_EVT   = BASE_ADDR + 16'd2;
   localparam logic [15:0] ADDR_STAT  = BASE_ADDR + 16'd4;

   logic [N_IN-1:0] s1;
   logic [N_IN-1:0] s2;
   logic [N_IN-1:0] lvl;
   logic [N_IN-1:0] lvl_next;
   logic [N_IN-1:0] evt;
   logic [N_IN-1:0] evt_next;
   logic [N_IN-1:0] rise;
   logic [3:0]      cnt      [N_IN];
   logic [3:0]      cnt_next [N_IN];
   logic [PW-1:0]   pre;
   logic            tick;
   logic            ovf;
   logic            ovf_next;
   logic            irq_q;
   logic            rd_evt;
   logic            rd_stat;

   assign tick = (pre == PW'(TICK_DIV - 1));

   // A line only moves to a new level after STABLE_CNT consecutive ticks disagree with it.
   always_comb begin
      lvl_next = lvl;
      for (int i = 0; i < N_IN; i++) begin
         cnt_next[i] = cnt[i];
         if (tick) begin
            if (s2[i] == lvl[i]) begin
               cnt_next[i] = 4'd0;
            end else if (cnt[i] + 4'd1 == 4'(STABLE_CNT)) begin
               lvl_next[i] = s2[i];
               cnt_next[i] = 4'd0;
            end else begin
               cnt_next[i] = cnt[i] + 4'd1;
            end
         end
      end
   end

   assign rise = lvl_next & ~lvl;

   // rd_en is a one-cycle load strobe: data is returned combinationally in that cycle
   // and any read side effect lands on the rising edge that closes it.
   assign hit     = (addr == ADDR_STATE) || (addr == ADDR_EVT) || (addr == ADDR_STAT);
   assign rd_evt  = rd_en && (addr == ADDR_EVT);
   assign rd_stat = rd_en && (addr == ADDR_STAT);

   always_comb begin
      rd_data = 16'h0000;
      if (rd_en) begin
         case (addr)
            ADDR_STATE: rd_data = 16'(lvl);
            ADDR_EVT:   rd_data = 16'(evt);
            ADDR_STAT:  rd_data = {14'd0, ovf, |evt};
            default:    rd_data = 16'h0000;
         endcase
      end
   end

   // A press arriving on the clearing edge wins, so no event is lost.
   assign evt_next = rise | (evt & ~{N_IN{rd_evt}});
   assign ovf_next = (|(rise & evt)) | (ovf & ~rd_stat);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         s1    <= '0;
         s2    <= '0;
         lvl   <= '0;
         evt   <= '0;
         pre   <= '0;
         ovf   <= 1'b0;
         irq_q <= 1'b0;
         for (int i = 0; i < N_IN; i++) cnt[i] <= 4'd0;
      end else begin
         s1    <= sw_in;
         s2    <= s1;
         lvl   <= lvl_next;
         evt   <= evt_next;
         ovf   <= ovf_next;
         irq_q <= |evt_next;
         pre   <= tick ? '0 : pre + PW'(1);
         for (int i = 0; i < N_IN; i++) cnt[i] <= cnt_next[i];
      end
   end

   assign irq_pending = irq_q;

endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
- Memory-mapped input peripheral for the 16-bit single-cycle CPU. It is the read-side counterpart of the memory-mapped digit display outputs.
- Synchronises and debounces N_IN external switch/key lines.
- Latches press events as sticky flags and returns them to the CPU on load accesses that hit its address window.
- Sits beside DataMemory on the same address/result bus; the top level muxes its rd_data into the load path when hit=1.

Parameters:
- N_IN, 8, number of input lines (1..16).
- BASE_ADDR, 16'hFF00, base byte address of the register window (word registers at +0, +2, +4).
- TICK_DIV, 1000, CLK cycles per debounce sample tick (>=2).
- STABLE_CNT, 4, consecutive differing samples required to accept a new level (1..15).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-low reset.
- sw_in  input  N_IN  raw asynchronous switch/key inputs, 1 = pressed.
- addr  input  16  CPU data address (ALU result).
- rd_en  input  1  CPU load strobe for this cycle.
- rd_data  output  16  read data, combinational.
- hit  output  1  addr is inside the window (BASE_ADDR, +2, +4), combinational.
- irq_pending  output  1  registered, 1 when any event flag is set.

Behaviour:
- Reset (RESET=0 at a rising edge):
  - sync flops, debounced levels, per-line counters, prescaler, event flags and ovf all clear to 0.
  - irq_pending=0. rd_data follows the cleared state.
- Synchroniser: two flops per line (s1, s2); s2 is the sampled value.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle where count==TICK_DIV-1.
- Debounce, per line i, evaluated only on tick:
  - s2[i]==lvl[i]: cnt[i]<=0.
  - otherwise cnt[i]<=cnt[i]+1.
  - When cnt[i]+1==STABLE_CNT: lvl[i]<=s2[i] and cnt[i]<=0 in the same edge.
  - Worst-case latency from a clean input change to the lvl update: 2 + TICK_DIV*STABLE_CNT cycles.
  - A glitch shorter than one tick period never changes lvl.
- Press event: rise[i]=1 on the edge where lvl[i] goes 0->1. Release (1->0) produces no event.
- Register map (byte offsets from BASE_ADDR):
  - +0 SW_STATE: {zeros, lvl}. Read-only, no side effect.
  - +2 KEY_EVENT: {zeros, evt}. Read-to-clear.
  - +4 STATUS: bit0 = |evt, bit1 = ovf, rest 0. Read clears ovf.
- Addresses outside these three words: hit=0, rd_data=16'h0000.
- Read timing:
  - rd_data is valid combinationally in the same cycle that addr and rd_en are presented (single-cycle CPU).
  - rd_data=0 when rd_en=0 or hit=0.
- Side effects take place at the rising edge that ends the read cycle.
- evt update, per bit, same edge:
  - set if rise[i].
  - else clear if (KEY_EVENT read).
  - else hold.
  - Set wins over clear: a press coinciding with the clearing read stays pending and is not lost.
- ovf:
  - set when rise[i] && evt[i] for any i (press while still pending).
  - cleared on STATUS read unless a new overflow occurs in that same edge (set wins).
- irq_pending<=|evt_next, registered, so it lags evt by 0 cycles relative to the evt register.
- A read of SW_STATE has no side effects. rd_en with hit=0 has no effect.
- Unused upper bits of all registers read 0 when N_IN<16.
- Reset mid-debounce discards partial counts. Reset with pending events discards them.

Test Plan:
- Reset: TICK_DIV=4, STABLE_CNT=3; hold RESET=0 for 3 cycles, read +0, +2, +4 -> all 16'h0000; irq_pending=0.
- Clean press of sw_in[2]=1:
  - SW_STATE reads 16'h0004 no later than 2+12 cycles after the change, and not before 2+8.
  - KEY_EVENT reads 16'h0004 and irq_pending=1.
  - A second KEY_EVENT read returns 16'h0000 and irq_pending=0.
- Bounce: sw_in[0] toggles every 3 cycles for 40 cycles, then settles to 0 -> SW_STATE bit0 never set, KEY_EVENT=0.
- Overflow: press and release sw_in[1] twice without reading KEY_EVENT:
  - STATUS reads 16'h0003.
  - A second STATUS read returns 16'h0001.
  - KEY_EVENT=16'h0002.
- Set/clear collision: force rise[5] in the same cycle as a KEY_EVENT read while evt=16'h0001:
  - that read returns 16'h0001.
  - the next read returns 16'h0020.
- Decode: addr=16'hFF06 or 16'h0010 with rd_en=1 -> hit=0, rd_data=0, no flags cleared. rd_en=0 at 16'hFF02 -> no clear.
